// File: rtl/counter_ctrl.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// counter_ctrl
// Runs a free counter for a requested number of laps and checks every step.
// A lap is one rising edge of the counter's terminal flag (cnt_done). While a
// run is active, every observed counter value is compared with the previous
// value and the enable that was driven, and any mismatch latches err_seq.
//
// Ports
//   clk         single clock, rising edge
//   reset       asynchronous, active-low (shared with the counter)
//   start       run request, accepted only when idle
//   laps        lap count, sampled on an accepted start
//   pause       level: drop the enable while high (HOLD)
//   abort       level: end the run without a finished pulse
//   cnt_out     counter value
//   cnt_done    counter terminal flag
//   cnt_enable  registered enable to the counter
//   busy        high while running or holding
//   finished    one-cycle pulse on normal completion
//   laps_left   laps still to be counted
//   err_seq     sticky sequence-error flag, cleared by an accepted start
// ---------------------------------------------------------------------------
module counter_ctrl #(
   parameter int WIDTH = 4,
   parameter int LAP_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [LAP_W-1:0] laps,
   input  logic             pause,
   input  logic             abort,
   input  logic [WIDTH-1:0] cnt_out,
   input  logic             cnt_done,
   output logic             cnt_enable,
   output logic             busy,
   output logic             finished,
   output logic [LAP_W-1:0] laps_left,
   output logic             err_seq
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      HOLD   = 2'd2,
      FINISH = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [LAP_W-1:0]   laps_left_q, laps_left_d;
   logic               err_seq_q, err_seq_d;
   logic               cnt_enable_q, cnt_enable_d;
   logic [WIDTH-1:0]   out_q, out_d;
   logic               en_q, en_d;
   logic               done_q, done_d;
   logic               chk_valid_q, chk_valid_d;

   logic               active;
   logic               done_ev;
   logic [WIDTH-1:0]   exp_out;
   logic               seq_bad;

   // The step check compares the value seen now with the value seen one
   // cycle earlier; the counter moves only if we enabled it last cycle.
   // The increment wraps naturally at WIDTH bits.
   always_comb begin
      active  = (state_q == RUN) || (state_q == HOLD);
      done_ev = cnt_done & ~done_q;
      exp_out = en_q ? (out_q + WIDTH'(1)) : out_q;
      seq_bad = active && chk_valid_q && (cnt_out != exp_out);
   end

   // Next-state logic. Abort beats a done event, which beats pause, so a lap
   // that coincides with an abort is not counted.
   always_comb begin
      state_d     = state_q;
      laps_left_d = laps_left_q;
      err_seq_d   = err_seq_q;
      chk_valid_d = chk_valid_q;
      out_d       = cnt_out;
      en_d        = cnt_enable_q;
      done_d      = cnt_done;

      case (state_q)
         IDLE: begin
            if (start) begin
               err_seq_d = 1'b0;
               if (laps != '0) begin
                  laps_left_d = laps;
                  chk_valid_d = 1'b0;
                  state_d     = RUN;
               end else begin
                  state_d     = FINISH;
               end
            end
         end
         RUN, HOLD: begin
            if (seq_bad) begin
               err_seq_d = 1'b1;
            end
            // The first RUN cycle has no trustworthy previous sample.
            if (state_q == RUN) begin
               chk_valid_d = 1'b1;
            end
            if (abort) begin
               state_d = IDLE;
            end else if (done_ev) begin
               laps_left_d = laps_left_q - LAP_W'(1);
               if (laps_left_q == LAP_W'(1)) begin
                  state_d = FINISH;
               end else begin
                  state_d = pause ? HOLD : RUN;
               end
            end else begin
               state_d = pause ? HOLD : RUN;
            end
         end
         FINISH: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      cnt_enable_d = (state_d == RUN);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         laps_left_q  <= '0;
         err_seq_q    <= 1'b0;
         cnt_enable_q <= 1'b0;
         out_q        <= '0;
         en_q         <= 1'b0;
         done_q       <= 1'b0;
         chk_valid_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         laps_left_q  <= laps_left_d;
         err_seq_q    <= err_seq_d;
         cnt_enable_q <= cnt_enable_d;
         out_q        <= out_d;
         en_q         <= en_d;
         done_q       <= done_d;
         chk_valid_q  <= chk_valid_d;
      end
   end

   assign cnt_enable = cnt_enable_q;
   assign busy       = (state_q == RUN) || (state_q == HOLD);
   assign finished   = (state_q == FINISH);
   assign laps_left  = laps_left_q;
   assign err_seq    = err_seq_q;

endmodule

// File: doc/counter_ctrl.md
# counter_ctrl

Initiator/checker on the far side of the counter's enable/out/done interface. It accepts a start request with a lap count and drives `enable` until the counter has signalled `done` that many times. It checks every counter step for sequence errors and reports busy, finished and error status to the system controller. It sits between the system controller and one `counter` instance; `counter_ctrl` never resets the counter.

## Interface
- `WIDTH`, 4: counter output width; must match the counter instance.
- `LAP_W`, 8: width of the lap count and of the remaining-laps counter.
- `clk` input 1: single clock; all state updates on rising edge.
- `reset` input 1: asynchronous, active-low reset; the same net resets the counter.
- `start` input 1: request; accepted only in IDLE.
- `laps` input LAP_W: number of done events to wait for; sampled on accepted `start`.
- `pause` input 1: level; while high in RUN, enable is dropped (HOLD).
- `abort` input 1: level; terminates a run without `finished`.
- `cnt_out` input WIDTH: counter value.
- `cnt_done` input 1: counter terminal flag.
- `cnt_enable` output 1: registered enable to the counter.
- `busy` output 1: high in RUN or HOLD.
- `finished` output 1: one-cycle pulse on normal completion.
- `laps_left` output LAP_W: remaining laps.
- `err_seq` output 1: sticky sequence-error flag.

## Operation
- States: IDLE, RUN, HOLD, FINISH.
- **Reset:** state IDLE; all outputs 0; internal `out_q`, `en_q`, `done_q` and `chk_valid` are 0.
- **IDLE + start:**
  - If `laps != 0`: `laps_left <= laps`, `err_seq <= 0`, `chk_valid <= 0`, go to RUN.
  - If `laps == 0`: go to FINISH; `cnt_enable` never rises; `err_seq` is cleared.
- **RUN:** `cnt_enable = 1`.
  - `pause` moves to HOLD.
  - HOLD returns to RUN when `pause` is low.
  - `cnt_enable = 0` in HOLD.
- **FINISH:** lasts one cycle with `finished = 1`, then IDLE.
- **Done event:**
  - Defined as `cnt_done & ~done_q`, where `done_q` is `cnt_done` registered every cycle.
  - Counted only in RUN or HOLD: `laps_left <= laps_left - 1`.
  - If `laps_left` was 1, go to FINISH.
- **Abort:** in RUN or HOLD, `abort` goes to IDLE with no `finished` pulse. `laps_left` and `err_seq` hold their values.
- **Sequence check** (RUN/HOLD, when `chk_valid = 1`):
  - Expected: `cnt_out == out_q + 1` (mod 2^WIDTH) if `en_q`, else `cnt_out == out_q`.
  - A mismatch sets `err_seq`.
  - `out_q <= cnt_out`, `en_q <= cnt_enable` every cycle.
  - `chk_valid <= 1` after the first RUN cycle.
- **Priority:** `abort` > done event > `pause`.
  - Abort and done event in the same cycle: lap not counted.
  - Done event with `pause` high: lap counted; the pause still takes effect if the run is not finished.
- `start` outside IDLE is ignored. `laps` is ignored except on an accepted start.

## Timing
- **Start:** `start` sampled at edge N gives `busy` and `cnt_enable` high after edge N. The first counter increment happens at edge N+1.
- **Done to laps_left:** a `cnt_done` rise visible before edge M decrements `laps_left` after edge M.
- **Final lap:** after edge M, state is FINISH, `cnt_enable = 0` and `finished = 1`; IDLE follows after edge M+1.
  - Because `cnt_enable` is still high in the cycle `cnt_done` is first seen, the counter advances exactly once past the terminal value (wraps).
- **Pause:** `pause` high at edge P drops `cnt_enable` after edge P. The counter holds from edge P+1 onward. Releasing `pause` re-raises `cnt_enable` after the next edge.
- **Abort:** `cnt_enable` is 0 after the sampling edge.
- **Reset mid-run:** asynchronous return to IDLE with all outputs 0. No `finished` pulse.
- **Wrap:** `out_q = 2^WIDTH-1` with `en_q = 1` expects `cnt_out = 0`.

## Test plan
- **Two laps:** reset, counter at 0, `start` with `laps=2`.
  - Required: `laps_left` 2→1 on the first done rise and 1→0 on the second.
  - `finished` is high exactly one cycle; `cnt_enable` is low from the same edge.
  - `err_seq` stays 0 and `busy` is high only between start and FINISH.
- **Zero laps:** `start` with `laps=0`.
  - Required: FINISH the next cycle, `finished` = 1 for one cycle, `cnt_enable` stays 0, `cnt_out` unchanged.
- **Pause:** `laps=1`, `pause` held high for 6 cycles mid-run.
  - Required: `cnt_out` is frozen for those cycles and no `err_seq`.
  - `finished` arrives 6 cycles later than in an unpaused run.
- **Abort:** `laps=3`, `abort` asserted after the first done event.
  - Required: IDLE, `laps_left = 2`, no `finished` pulse, `cnt_enable = 0` next cycle.
  - A later `start` with `laps=1` completes normally.
- **Sequence error:** bench-forced `cnt_out` skip (5→7 with enable high).
  - Required: `err_seq = 1` the following cycle and it stays set through the end of the run.
  - The next accepted `start` clears it.
- **Reset and ignored start:** `reset` low mid-run, then released; assert `start` while busy.
  - Required: on reset, all outputs 0 immediately and no `finished`.
  - Required: the busy-time `start` is ignored and `laps_left` is unchanged.
